// File: rtl/game_flow_ctrl.sv
// Breakout game sequencer: tracks lives, gates play, and picks the active screen.
// All state advances are qualified by frame boundaries or single-cycle physics events.
module game_flow_ctrl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       play_en,
  output logic       serve_req,
  output logic       new_game,
  output logic [1:0] screen_sel,
  output logic       text_on
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LIVES_W = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] LOSE  = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;

  localparam logic [1:0] SCR_FIELD = 2'd0;
  localparam logic [1:0] SCR_OVER  = 2'd1;
  localparam logic [1:0] SCR_WIN   = 2'd2;
  localparam logic [1:0] SCR_TITLE = 2'd3;

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_MAX   = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [CNT_W-1:0]   blink_cnt, blink_cnt_nxt;
  logic               start_prev;
  logic               start_press;
  logic [2:0]         state_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic               play_en_nxt, serve_req_nxt, new_game_nxt, text_on_nxt;
  logic [1:0]         screen_sel_nxt;
  logic               text_state_nxt;

  assign start_press = start_btn & ~start_prev;

  // State and registered-output update
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lives      <= LIVES_LOAD;
      play_en    <= 1'b0;
      serve_req  <= 1'b0;
      new_game   <= 1'b0;
      screen_sel <= SCR_TITLE;
      text_on    <= 1'b1;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      lives      <= lives_nxt;
      play_en    <= play_en_nxt;
      serve_req  <= serve_req_nxt;
      new_game   <= new_game_nxt;
      screen_sel <= screen_sel_nxt;
      text_on    <= text_on_nxt;
      frame_cnt  <= frame_cnt_nxt;
      blink_cnt  <= blink_cnt_nxt;
      start_prev <= start_btn;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nxt      = state;
    lives_nxt      = lives;
    frame_cnt_nxt  = frame_cnt;
    blink_cnt_nxt  = blink_cnt;
    serve_req_nxt  = 1'b0;
    new_game_nxt   = 1'b0;
    text_on_nxt    = 1'b1;
    screen_sel_nxt = SCR_FIELD;

    case (state)
      IDLE: begin
        if (start_press) begin
          state_nxt     = SERVE;
          lives_nxt     = LIVES_LOAD;
          new_game_nxt  = 1'b1;
          serve_req_nxt = 1'b1;
          frame_cnt_nxt = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) begin
            state_nxt     = PLAY;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        // A clear on the same cycle as a lost ball still counts as a win
        if (bricks_cleared) begin
          state_nxt     = WIN;
          frame_cnt_nxt = '0;
        end else if (ball_lost) begin
          state_nxt = LOSE;
        end
      end
      LOSE: begin
        frame_cnt_nxt = '0;
        if (lives <= LIVES_W'(1)) begin
          lives_nxt = '0;
          state_nxt = OVER;
        end else begin
          lives_nxt     = lives - LIVES_W'(1);
          serve_req_nxt = 1'b1;
          state_nxt     = SERVE;
        end
      end
      OVER, WIN: begin
        if (frame_cnt >= HOLD_MAX) begin
          if (start_press) state_nxt = IDLE;
        end else if (frame_tick) begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    play_en_nxt    = (state_nxt == PLAY);
    text_state_nxt = (state_nxt == IDLE) || (state_nxt == OVER) || (state_nxt == WIN);

    case (state_nxt)
      IDLE:    screen_sel_nxt = SCR_TITLE;
      OVER:    screen_sel_nxt = SCR_OVER;
      WIN:     screen_sel_nxt = SCR_WIN;
      default: screen_sel_nxt = SCR_FIELD;
    endcase

    // Text blinks only while staying in a text screen; any entry restarts it lit
    if (!text_state_nxt || (state_nxt != state)) begin
      blink_cnt_nxt = '0;
      text_on_nxt   = 1'b1;
    end else begin
      text_on_nxt = text_on;
      if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt = '0;
          text_on_nxt   = ~text_on;
        end else begin
          blink_cnt_nxt = blink_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: serve timing, lives, hold, win priority, masking, reset.
module tb_game_flow_ctrl;

  logic       clock = 1'b0;
  logic       reset, frame_tick, start_btn, ball_lost, bricks_cleared;
  logic [2:0] state;
  logic [1:0] lives;
  logic       play_en, serve_req, new_game, text_on;
  logic [1:0] screen_sel;

  int n_assert = 0;
  int n_fail   = 0;

  game_flow_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .start_btn      (start_btn),
    .ball_lost      (ball_lost),
    .bricks_cleared (bricks_cleared),
    .state          (state),
    .lives          (lives),
    .play_en        (play_en),
    .serve_req      (serve_req),
    .new_game       (new_game),
    .screen_sel     (screen_sel),
    .text_on        (text_on)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One frame = 4 clocks, tick on the first
  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  int'(state), 0);
    chk({tag, "_lives"},  int'(lives), 3);
    chk({tag, "_play"},   int'(play_en), 0);
    chk({tag, "_serve"},  int'(serve_req), 0);
    chk({tag, "_newg"},   int'(new_game), 0);
    chk({tag, "_scr"},    int'(screen_sel), 3);
    chk({tag, "_text"},   int'(text_on), 1);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
    ball_lost = 1'b0; bricks_cleared = 1'b0;

    // Bring-up
    repeat (2) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    frames(10);
    chk("idle10_state", int'(state), 0);
    chk("idle10_text", int'(text_on), 1);
    frames(19);
    chk("idle29_text", int'(text_on), 1);
    frame();
    chk("idle30_text", int'(text_on), 0);

    // New game; button held throughout serve
    start_btn = 1'b1;
    step();
    chk("start_state", int'(state), 1);
    chk("start_newg", int'(new_game), 1);
    chk("start_serve", int'(serve_req), 1);
    chk("start_scr", int'(screen_sel), 0);
    chk("start_text", int'(text_on), 1);
    step();
    chk("start_newg_off", int'(new_game), 0);
    chk("start_serve_off", int'(serve_req), 0);
    frames(59);
    chk("serve59_state", int'(state), 1);
    chk("held_no_newg", int'(new_game), 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("serve60_state", int'(state), 2);
    chk("serve60_play", int'(play_en), 1);
    start_btn = 1'b0;
    step();

    // First loss
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("lose1_state", int'(state), 3);
    chk("lose1_lives", int'(lives), 3);
    chk("lose1_play", int'(play_en), 0);
    step();
    chk("lose1_next", int'(state), 1);
    chk("lose1_lives2", int'(lives), 2);
    chk("lose1_serve", int'(serve_req), 1);
    frames(60);
    chk("replay1_state", int'(state), 2);

    // Second loss
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    step();
    chk("lose2_lives", int'(lives), 1);
    chk("lose2_serve", int'(serve_req), 1);
    frames(60);
    chk("replay2_state", int'(state), 2);

    // Final loss
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("lose3_state", int'(state), 3);
    step();
    chk("over_state", int'(state), 4);
    chk("over_lives", int'(lives), 0);
    chk("over_scr", int'(screen_sel), 1);
    chk("over_play", int'(play_en), 0);
    chk("over_serve", int'(serve_req), 0);
    chk("over_text", int'(text_on), 1);

    // Game-over hold
    frames(50);
    chk("over50_text", int'(text_on), 0);
    start_btn = 1'b1;
    step();
    chk("over50_press", int'(state), 4);
    start_btn = 1'b0;
    step();
    frames(69);
    start_btn = 1'b1;
    step();
    chk("over119_press", int'(state), 4);
    start_btn = 1'b0;
    step();
    frame();
    chk("over120_text", int'(text_on), 1);
    start_btn = 1'b1;
    step();
    chk("over120_state", int'(state), 0);
    chk("over120_scr", int'(screen_sel), 3);
    start_btn = 1'b0;
    step();

    // Win priority
    start_btn = 1'b1;
    step();
    chk("game2_lives", int'(lives), 3);
    chk("game2_newg", int'(new_game), 1);
    start_btn = 1'b0;
    frames(60);
    chk("game2_play", int'(state), 2);
    ball_lost = 1'b1; bricks_cleared = 1'b1;
    step();
    ball_lost = 1'b0; bricks_cleared = 1'b0;
    chk("win_state", int'(state), 5);
    chk("win_scr", int'(screen_sel), 2);
    chk("win_lives", int'(lives), 3);
    chk("win_play", int'(play_en), 0);
    frames(10);
    start_btn = 1'b1;
    step();
    chk("win_hold_press", int'(state), 5);
    start_btn = 1'b0;

    // Reset mid-hold
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_hold");

    // Masking in SERVE, then reset mid-serve
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("game3_state", int'(state), 1);
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("mask_lost_state", int'(state), 1);
    chk("mask_lost_lives", int'(lives), 3);
    bricks_cleared = 1'b1;
    step();
    bricks_cleared = 1'b0;
    chk("mask_clear_state", int'(state), 1);
    frames(30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_serve");

    // Serve length intact after reset
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    frames(59);
    chk("serve_after_rst59", int'(state), 1);
    frame();
    chk("serve_after_rst60", int'(state), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
